fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pc_sel_i  input  1  redirect request from control logic, qualified by consume.
REQ-005 SHALL have port alu_target_i  input  32  redirect target address.
REQ-006 SHALL have port stall_i  input  1  downstream not accepting the current instruction.
REQ-007 SHALL have port imem_req_o  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr_o  output  32  request address; held stable while imem_req_o is high and no ack.
REQ-009 SHALL have port imem_ack_i  input  1  request complete; imem_rdata_i valid this cycle; may coincide with the request cycle.
REQ-010 SHALL have port imem_rdata_i  input  32  fetched instruction word.
REQ-011 SHALL have port inst_o  output  32  instruction to decode/control logic, registered.
REQ-012 SHALL have port pc_o  output  32  address of inst_o, registered.
REQ-013 SHALL have port pc4_o  output  32  pc_o + 4, modulo 2^32.
REQ-014 SHALL have port inst_valid_o  output  1  inst_o/pc_o hold a live instruction.
REQ-015 SHALL have port misalign_o  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL define consume = inst_valid_o & ~stall_i and redirect = consume & pc_sel_i.
REQ-017 SHALL hold internal fetch_pc, a 1-entry skid buffer (word, pc, valid), and FSM states FETCH, FULL, FLUSH, HALT.
REQ-018 FETCH: SHALL drive imem_req_o=1 and imem_addr_o=fetch_pc.
REQ-019 FETCH, ack & ~redirect: SHALL load rdata/fetch_pc into the outputs if ~inst_valid_o | consume; otherwise into the skid buffer and go to FULL; fetch_pc += 4 either way.
REQ-020 FETCH, ~ack & consume & ~pc_sel_i: SHALL clear inst_valid_o.
REQ-021 FETCH, redirect & ack: SHALL discard rdata, clear inst_valid_o, set fetch_pc=alu_target_i, and stay in FETCH.
REQ-022 FETCH, redirect & ~ack: SHALL keep imem_addr_o unchanged, latch alu_target_i into redir_pc, clear inst_valid_o, and go to FLUSH.
REQ-023 FULL: SHALL drive imem_req_o=0; on consume & ~pc_sel_i, move the skid buffer into the outputs, invalidate the skid buffer, and go to FETCH.
REQ-024 FULL, redirect: SHALL invalidate the skid buffer, clear inst_valid_o, set fetch_pc=alu_target_i, and go to FETCH.
REQ-025 FLUSH: SHALL keep imem_req_o=1 with the old address; on ack, discard rdata, set fetch_pc=redir_pc, and go to FETCH.
REQ-026 SHALL ignore pc_sel_i when inst_valid_o=0, and SHALL hold inst_o/pc_o stable while inst_valid_o & stall_i.
REQ-027 SHALL allow one outstanding memory request at most, and SHALL never lose or duplicate an instruction.
REQ-028 fetch_pc arithmetic SHALL wrap 32'hFFFF_FFFC + 4 to 32'h0000_0000.

Reset
REQ-029 On rst_i=1 at a clock edge, SHALL enter FETCH, set fetch_pc=RESET_PC, clear inst_valid_o, skid valid, and misalign_o, and set inst_o=32'h0000_0013 and pc_o=RESET_PC.
REQ-030 While rst_i=1, SHALL ignore imem_ack_i; a request in flight at reset is abandoned, and the fetch restarts at RESET_PC.

Configuration
REQ-031 With macro FETCH_MISALIGN_CHK_EN defined, a redirect with alu_target_i[1:0]!=0 SHALL enter HALT: imem_req_o=0, inst_valid_o=0, misalign_o=1 until reset; an outstanding request is first completed as in FLUSH, then HALT.
REQ-032 Without FETCH_MISALIGN_CHK_EN, misalign_o SHALL be tied 0, alu_target_i[1:0] SHALL be forced to 2'b00, and HALT SHALL be unreachable.

Verification
REQ-033 Scenario: reset, then ack every cycle, stall_i=0 -> imem_addr_o 0x0,0x4,0x8; pc_o follows one cycle later; inst_valid_o stays 1.
REQ-034 Scenario: stall_i=1 for 3 cycles with ack=1 -> one word goes to the skid buffer; FULL with req=0; after unstall, the outputs show pc 0x4 then 0x8, and nothing is dropped.
REQ-035 Scenario: pc_sel_i=1, alu_target_i=0x100, request pending with ack 2 cycles late -> FLUSH; the late word is discarded; the next imem_addr_o is 0x100.
REQ-036 Scenario: redirect to 0x200 in the same cycle as ack -> rdata is discarded; imem_addr_o=0x200 on the next cycle.
REQ-037 Scenario: rst_i asserted mid-request -> the next cycle shows imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0x13.
REQ-038 Scenario: with FETCH_MISALIGN_CHK_EN, redirect to 0x102 -> misalign_o=1 and req=0 until reset; without the macro, the fetch proceeds at 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues one instruction-memory request
//               at a time, presents fetched words on registered outputs and
//               parks one word in a skid buffer when the consumer stalls.
//               Handles redirects that arrive with or without a pending
//               memory response.
//               Optional feature: define FETCH_MISALIGN_CHK_EN to halt fetch
//               on a redirect to a non-word-aligned target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_sel_i,
    input  logic [31:0] alu_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        inst_valid_o,
    output logic        misalign_o
);

    localparam logic [1:0]  c_st_fetch = 2'd0;
    localparam logic [1:0]  c_st_full  = 2'd1;
    localparam logic [1:0]  c_st_flush = 2'd2;
    localparam logic [1:0]  c_st_halt  = 2'd3;

    localparam logic [31:0] c_nop      = 32'h0000_0013;
    localparam logic [31:0] c_pc_step  = 32'd4;

    // Registered state
    logic [1:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_redir_pc;
    logic        r_halt_pend;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;

    // Next-state values
    logic [1:0]  w_state_nxt;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] w_redir_pc_nxt;
    logic        w_halt_pend_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_skid_inst_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic        w_skid_valid_nxt;
    logic        w_misalign_nxt;
    logic        w_req;

    // Handshake qualifiers
    logic        w_consume;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_target_bad;

    assign w_consume  = r_valid & ~stall_i;
    assign w_redirect = w_consume & pc_sel_i;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_target     = alu_target_i;
    assign w_target_bad = |alu_target_i[1:0];
`else
    // Low target bits are dropped so every redirect lands on a word boundary.
    logic w_unused_target_lsbs;
    assign w_unused_target_lsbs = ^alu_target_i[1:0];
    assign w_target             = {alu_target_i[31:2], 2'b00};
    assign w_target_bad         = 1'b0;
`endif

    // Next-state and request decode for the fetch FSM and its datapath
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_redir_pc_nxt   = r_redir_pc;
        w_halt_pend_nxt  = r_halt_pend;
        w_inst_nxt       = r_inst;
        w_pc_nxt         = r_pc;
        w_valid_nxt      = r_valid;
        w_skid_inst_nxt  = r_skid_inst;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_valid_nxt = r_skid_valid;
        w_misalign_nxt   = 1'b0;
        w_req            = 1'b0;

        case (r_state)
            c_st_fetch: begin
                w_req = 1'b1;
                if (w_redirect) begin
                    w_valid_nxt = 1'b0;
                    if (imem_ack_i) begin
                        // Response arrives with the redirect: drop the word.
                        if (w_target_bad) begin
                            w_state_nxt    = c_st_halt;
                            w_misalign_nxt = 1'b1;
                        end else begin
                            w_fetch_pc_nxt = w_target;
                        end
                    end else begin
                        // Request still outstanding: finish it, then jump.
                        w_redir_pc_nxt  = w_target;
                        w_halt_pend_nxt = w_target_bad;
                        w_state_nxt     = c_st_flush;
                    end
                end else if (imem_ack_i) begin
                    w_fetch_pc_nxt = r_fetch_pc + c_pc_step;
                    if (!r_valid || w_consume) begin
                        w_inst_nxt  = imem_rdata_i;
                        w_pc_nxt    = r_fetch_pc;
                        w_valid_nxt = 1'b1;
                    end else begin
                        // Output slot occupied and held: park the word.
                        w_skid_inst_nxt  = imem_rdata_i;
                        w_skid_pc_nxt    = r_fetch_pc;
                        w_skid_valid_nxt = 1'b1;
                        w_state_nxt      = c_st_full;
                    end
                end else if (w_consume) begin
                    w_valid_nxt = 1'b0;
                end
            end

            c_st_full: begin
                if (w_redirect) begin
                    w_skid_valid_nxt = 1'b0;
                    w_valid_nxt      = 1'b0;
                    if (w_target_bad) begin
                        w_state_nxt    = c_st_halt;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_fetch_pc_nxt = w_target;
                        w_state_nxt    = c_st_fetch;
                    end
                end else if (w_consume) begin
                    w_inst_nxt       = r_skid_inst;
                    w_pc_nxt         = r_skid_pc;
                    w_skid_valid_nxt = 1'b0;
                    w_state_nxt      = c_st_fetch;
                end
            end

            c_st_flush: begin
                // Address stays on the abandoned fetch until memory answers.
                w_req = 1'b1;
                if (imem_ack_i) begin
                    w_halt_pend_nxt = 1'b0;
                    if (r_halt_pend) begin
                        w_state_nxt    = c_st_halt;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_fetch_pc_nxt = r_redir_pc;
                        w_state_nxt    = c_st_fetch;
                    end
                end
            end

            c_st_halt: begin
                w_valid_nxt      = 1'b0;
                w_skid_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = c_st_fetch;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_st_fetch;
            r_fetch_pc   <= RESET_PC;
            r_redir_pc   <= RESET_PC;
            r_halt_pend  <= 1'b0;
            r_inst       <= c_nop;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_skid_inst  <= c_nop;
            r_skid_pc    <= RESET_PC;
            r_skid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
            r_halt_pend  <= w_halt_pend_nxt;
            r_inst       <= w_inst_nxt;
            r_pc         <= w_pc_nxt;
            r_valid      <= w_valid_nxt;
            r_skid_inst  <= w_skid_inst_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_valid <= w_skid_valid_nxt;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign;

    // Sticky misalign flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_nxt) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_o = r_misalign;
`else
    logic w_unused_misalign;
    assign w_unused_misalign = w_misalign_nxt;
    assign misalign_o        = 1'b0;
`endif

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_fetch_pc;
    assign inst_o       = r_inst;
    assign pc_o         = r_pc;
    assign pc4_o        = r_pc + c_pc_step;
    assign inst_valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed vector table,
//               reset-during-request sequence and randomized traffic checked
//               against an in-order instruction-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pc_sel_i;
    logic [31:0] alu_target_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic        inst_valid_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_sel_i     (pc_sel_i),
        .alu_target_i (alu_target_i),
        .stall_i      (stall_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .pc4_o        (pc4_o),
        .inst_valid_o (inst_valid_o),
        .misalign_o   (misalign_o)
    );

    // Memory contents are a fixed function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;
        logic        stall;
        logic        sel;
        logic [31:0] tgt;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        mis;
    } vec_t;

    vec_t tbl [0:23];
    int   n_rows;

    task automatic set_row(input int i, input logic a, input logic s, input logic p,
                           input logic [31:0] t, input logic rq, input logic ca,
                           input logic [31:0] ad, input logic v, input logic [31:0] pc,
                           input logic m);
        tbl[i].ack = a;  tbl[i].stall = s; tbl[i].sel = p; tbl[i].tgt = t;
        tbl[i].req = rq; tbl[i].chk_addr = ca; tbl[i].addr = ad;
        tbl[i].valid = v; tbl[i].pc = pc; tbl[i].mis = m;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] tw;
        int          idle;
        logic        p_valid, p_stall, p_req, p_ack;
        logic [31:0] p_pc, p_inst, p_addr;

        //          ack stl sel target        req ca addr          vld pc            mis
        set_row( 0, 1,  0,  0,  32'h0,         1,  1, 32'h0,         0,  32'h0,         0);
        set_row( 1, 1,  0,  0,  32'h0,         1,  1, 32'h4,         1,  32'h0,         0);
        set_row( 2, 1,  1,  0,  32'h0,         1,  1, 32'h8,         1,  32'h4,         0);
        set_row( 3, 0,  1,  0,  32'h0,         0,  0, 32'h0,         1,  32'h4,         0);
        set_row( 4, 0,  1,  0,  32'h0,         0,  0, 32'h0,         1,  32'h4,         0);
        set_row( 5, 0,  0,  0,  32'h0,         0,  0, 32'h0,         1,  32'h4,         0);
        set_row( 6, 0,  0,  0,  32'h0,         1,  1, 32'hC,         1,  32'h8,         0);
        set_row( 7, 1,  0,  0,  32'h0,         1,  1, 32'hC,         0,  32'h8,         0);
        set_row( 8, 0,  0,  1,  32'h100,       1,  1, 32'h10,        1,  32'hC,         0);
        set_row( 9, 0,  0,  1,  32'h100,       1,  1, 32'h10,        0,  32'hC,         0);
        set_row(10, 1,  0,  0,  32'h0,         1,  1, 32'h10,        0,  32'hC,         0);
        set_row(11, 1,  0,  0,  32'h0,         1,  1, 32'h100,       0,  32'hC,         0);
        set_row(12, 1,  0,  1,  32'h200,       1,  1, 32'h104,       1,  32'h100,       0);
        set_row(13, 0,  0,  0,  32'h0,         1,  1, 32'h200,       0,  32'h100,       0);
        set_row(14, 1,  0,  1,  32'h102,       1,  1, 32'h200,       0,  32'h100,       0);
        set_row(15, 0,  0,  1,  32'h102,       1,  1, 32'h204,       1,  32'h200,       0);
        set_row(16, 1,  0,  0,  32'h0,         1,  1, 32'h204,       0,  32'h200,       0);
        set_row(17, 1,  0,  0,  32'h0,         1,  1, 32'h100,       0,  32'h200,       0);
        set_row(18, 0,  0,  0,  32'h0,         1,  1, 32'h104,       1,  32'h100,       0);
        set_row(19, 1,  0,  0,  32'h0,         1,  1, 32'h104,       0,  32'h100,       0);
        set_row(20, 1,  0,  1,  32'hFFFF_FFFC, 1,  1, 32'h108,       1,  32'h104,       0);
        set_row(21, 1,  0,  0,  32'h0,         1,  1, 32'hFFFF_FFFC, 0,  32'h104,       0);
        set_row(22, 1,  0,  0,  32'h0,         1,  1, 32'h0,         1,  32'hFFFF_FFFC, 0);
        set_row(23, 0,  0,  0,  32'h0,         1,  1, 32'h4,         1,  32'h0,         0);
        n_rows = 24;
`ifdef FETCH_MISALIGN_CHK_EN
        // Redirect to 0x102 drains the pending request, then halts.
        set_row(17, 1,  0,  0,  32'h0,         0,  0, 32'h0,         0,  32'h200,       1);
        set_row(18, 0,  0,  0,  32'h0,         0,  0, 32'h0,         0,  32'h200,       1);
        n_rows = 19;
`endif

        // Reset and check the reset state
        rst_i = 1'b1; pc_sel_i = 1'b0; alu_target_i = '0; stall_i = 1'b0; imem_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset_req",   {31'd0, imem_req_o},   32'd1);
        chk("reset_addr",  imem_addr_o,           32'h0);
        chk("reset_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("reset_inst",  inst_o,                32'h0000_0013);
        chk("reset_pc",    pc_o,                  32'h0);
        chk("reset_pc4",   pc4_o,                 32'h4);
        chk("reset_mis",   {31'd0, misalign_o},   32'd0);

        // Directed vector table
        for (int i = 0; i < n_rows; i++) begin
            imem_ack_i = tbl[i].ack; stall_i = tbl[i].stall;
            pc_sel_i = tbl[i].sel;   alu_target_i = tbl[i].tgt;
            #1;
            chk($sformatf("row%0d_req", i),   {31'd0, imem_req_o},   {31'd0, tbl[i].req});
            if (tbl[i].chk_addr)
                chk($sformatf("row%0d_addr", i), imem_addr_o, tbl[i].addr);
            chk($sformatf("row%0d_valid", i), {31'd0, inst_valid_o}, {31'd0, tbl[i].valid});
            chk($sformatf("row%0d_pc", i),    pc_o,                  tbl[i].pc);
            chk($sformatf("row%0d_pc4", i),   pc4_o,                 tbl[i].pc + 32'd4);
            if (tbl[i].valid)
                chk($sformatf("row%0d_inst", i), inst_o, mem_word(tbl[i].pc));
            chk($sformatf("row%0d_mis", i),   {31'd0, misalign_o},   {31'd0, tbl[i].mis});
            @(negedge clk_i);
        end

        // Reset asserted while a request is in flight; ack during reset ignored
        rst_i = 1'b1; imem_ack_i = 1'b1; stall_i = 1'b0; pc_sel_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_addr",  imem_addr_o,           32'h0);
        chk("midrst_req",   {31'd0, imem_req_o},   32'd1);
        chk("midrst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("midrst_inst",  inst_o,                32'h0000_0013);
        chk("midrst_pc",    pc_o,                  32'h0);
        chk("midrst_mis",   {31'd0, misalign_o},   32'd0);
        @(negedge clk_i);
        chk("midrst_hold_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("midrst_hold_addr",  imem_addr_o,           32'h0);
        rst_i = 1'b0; imem_ack_i = 1'b0;

        // Randomized traffic against an in-order instruction-stream model
        exp_pc = 32'h0; idle = 0;
        p_valid = 1'b0; p_stall = 1'b0; p_req = 1'b0; p_ack = 1'b0;
        p_pc = '0; p_inst = '0; p_addr = '0;
        for (int c = 0; c < 4000; c++) begin
            stall_i    = ($urandom_range(0, 99) < 30);
            imem_ack_i = imem_req_o & ($urandom_range(0, 1) == 1);
            pc_sel_i   = ($urandom_range(0, 4) == 0);
            tw         = $urandom();
`ifdef FETCH_MISALIGN_CHK_EN
            tw[1:0]    = 2'b00;
`endif
            alu_target_i = tw;
            #1;
            if (p_req && !p_ack && imem_req_o)
                chk("rnd_addr_hold", imem_addr_o, p_addr);
            if (p_valid && p_stall) begin
                chk("rnd_hold_valid", {31'd0, inst_valid_o}, 32'd1);
                chk("rnd_hold_pc",    pc_o,   p_pc);
                chk("rnd_hold_inst",  inst_o, p_inst);
            end
            chk("rnd_mis", {31'd0, misalign_o}, 32'd0);
            if (inst_valid_o && !stall_i) begin
                chk("rnd_pc",   pc_o,   exp_pc);
                chk("rnd_inst", inst_o, mem_word(exp_pc));
                chk("rnd_pc4",  pc4_o,  exp_pc + 32'd4);
                exp_pc = pc_sel_i ? {tw[31:2], 2'b00} : exp_pc + 32'd4;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 64) begin
                total++;
                bad++;
                $display("FAIL rnd_progress: got %0d idle cycles expected at most 64", idle);
                idle = 0;
            end
            p_valid = inst_valid_o; p_stall = stall_i; p_req = imem_req_o;
            p_ack = imem_ack_i; p_pc = pc_o; p_inst = inst_o; p_addr = imem_addr_o;
            @(negedge clk_i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
